// File: rtl/disp_arbiter.sv
// Two-requester round-robin display arbiter: captures the granted 16-bit value,
// converts it to BCD by sequential double-dabble, and holds it on the digit outputs.
//
// state   | meaning
// IDLE    | waiting for a request; grants one requester and captures its data
// CONVERT | one double-dabble step per cycle for 16 cycles, then loads the digits
// HOLD    | keeps the new value on display for HOLD_CYCLES cycles before re-arbitrating
module disp_arbiter #(
    parameter int HOLD_CYCLES = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic [1:0]  ack,
    output logic [3:0]  dig0,
    output logic [3:0]  dig1,
    output logic [3:0]  dig2,
    output logic [3:0]  dig3,
    output logic        busy,
    output logic        src
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    localparam int              HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    ack_q, ack_d;
    logic [15:0]   shift_q, shift_d;
    logic [19:0]   bcd_q, bcd_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          last_q, last_d;
    logic          gnt_q, gnt_d;
    logic [15:0]   disp_q, disp_d;
    logic          src_q, src_d;

    logic [19:0]   bcd_adj;
    logic          win;

    // Round-robin: a lone requester wins; on a tie the one not granted last wins.
    assign win = req[1] & (~req[0] | ~last_q);

    for (genvar i = 0; i < 5; i++) begin : g_add3
        assign bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                             : bcd_q[4*i +: 4];
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = 2'b00;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        bit_cnt_d  = bit_cnt_q;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        disp_d     = disp_q;
        src_d      = src_q;
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    ack_d     = win ? 2'b10 : 2'b01;
                    gnt_d     = win;
                    last_d    = win;
                    shift_d   = win ? data1 : data0;
                    bcd_d     = '0;
                    bit_cnt_d = 5'd16;
                    state_d   = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (bit_cnt_q != 5'd0) begin
                    bcd_d     = 20'({bcd_adj, shift_q[15]});
                    shift_d   = {shift_q[14:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 5'd1;
                end else begin
                    // A non-zero ten-thousands digit cannot be shown on four digits: show dashes.
                    disp_d     = (bcd_q[19:16] != 4'd0) ? 16'hAAAA : bcd_q[15:0];
                    src_d      = gnt_q;
                    hold_cnt_d = HOLD_LOAD;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ack_q      <= 2'b00;
            shift_q    <= '0;
            bcd_q      <= '0;
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
            last_q     <= 1'b1;
            gnt_q      <= 1'b0;
            disp_q     <= 16'hAAAA;
            src_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            disp_q     <= disp_d;
            src_q      <= src_d;
        end
    end

    assign ack  = ack_q;
    assign busy = (state_q != S_IDLE);
    assign src  = src_q;
    assign dig0 = disp_q[3:0];
    assign dig1 = disp_q[7:4];
    assign dig2 = disp_q[11:8];
    assign dig3 = disp_q[15:12];

endmodule

// File: tb/tb_disp_arbiter.sv
// Bench for disp_arbiter: directed and random requests predicted by a round-robin /
// decimal-digit model, checked by a negedge monitor against a queue of expected grants.
module tb_disp_arbiter;
    localparam int HOLD = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req   = 2'b11;
    logic [15:0] data0 = 16'd0;
    logic [15:0] data1 = 16'd0;
    logic [1:0]  ack;
    logic [3:0]  dig0, dig1, dig2, dig3;
    logic        busy;
    logic        src;

    disp_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .clock(clock), .reset(reset), .req(req), .data0(data0), .data1(data1),
        .ack(ack), .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
        .busy(busy), .src(src)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        w;
        logic [15:0] digits;
    } grant_t;

    grant_t      exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic        exp_last = 1'b1;
    logic [15:0] disp_exp = 16'hAAAA;
    logic        src_exp  = 1'b0;
    logic        rst_seen;
    bit          mon_active = 1'b0;
    int          mon_k = 0;
    grant_t      cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [15:0] to_digits(input int v);
        if (v >= 10000) return 16'hAAAA;
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic pick_winner(input logic [1:0] r, input logic last);
        if (r == 2'b01) return 1'b0;
        if (r == 2'b10) return 1'b1;
        return ~last;
    endfunction

    always @(posedge clock) rst_seen <= reset;

    // Monitor: mon_k counts rising edges since the grant edge of the current transaction.
    always @(negedge clock) begin
        logic [15:0] digs;
        digs = {dig3, dig2, dig1, dig0};
        if (rst_seen === 1'b0) begin
            mon_active = 1'b0;
            disp_exp   = 16'hAAAA;
            src_exp    = 1'b0;
            check("reset_ack", 32'(ack), 32'(2'b00));
            check("reset_busy", 32'(busy), 32'(1'b0));
            check("reset_digits", 32'(digs), 32'(disp_exp));
            check("reset_src", 32'(src), 32'(src_exp));
        end else if (!mon_active) begin
            if (ack !== 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 32'(2'b00));
                end else begin
                    cur = exp_q.pop_front();
                    check("grant_ack", 32'(ack), 32'(cur.w ? 2'b10 : 2'b01));
                    check("grant_busy", 32'(busy), 32'(1'b1));
                    check("grant_digits_kept", 32'(digs), 32'(disp_exp));
                    mon_active = 1'b1;
                    mon_k      = 0;
                end
            end else begin
                check("idle_busy", 32'(busy), 32'(1'b0));
                check("idle_digits", 32'(digs), 32'(disp_exp));
                check("idle_src", 32'(src), 32'(src_exp));
            end
        end else begin
            mon_k++;
            check("ack_one_cycle", 32'(ack), 32'(2'b00));
            if (mon_k < 17) begin
                check("convert_busy", 32'(busy), 32'(1'b1));
                check("convert_digits_kept", 32'(digs), 32'(disp_exp));
                check("convert_src_kept", 32'(src), 32'(src_exp));
            end else if (mon_k == 17) begin
                disp_exp = cur.digits;
                src_exp  = cur.w;
                check("load_digits", 32'(digs), 32'(disp_exp));
                check("load_src", 32'(src), 32'(src_exp));
                check("load_busy", 32'(busy), 32'(1'b1));
            end else if (mon_k < 17 + HOLD) begin
                check("hold_busy", 32'(busy), 32'(1'b1));
                check("hold_digits", 32'(digs), 32'(disp_exp));
            end else begin
                check("hold_end_busy", 32'(busy), 32'(1'b0));
                check("hold_end_digits", 32'(digs), 32'(disp_exp));
                mon_active = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(busy), 32'(1'b0));
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (ack === 2'b00 && n < 8);
        check("ack_seen", 32'(ack !== 2'b00), 32'(1'b1));
    endtask

    task automatic expect_grant(input logic [1:0] r, input logic [15:0] d0, input logic [15:0] d1,
                                output logic w);
        grant_t g;
        w        = pick_winner(r, exp_last);
        exp_last = w;
        g.w      = w;
        g.digits = to_digits(w ? int'(d1) : int'(d0));
        exp_q.push_back(g);
    endtask

    task automatic serve(input logic [1:0] r, input logic [15:0] d0, input logic [15:0] d1);
        logic w;
        wait_idle();
        expect_grant(r, d0, d1, w);
        data0 = d0;
        data1 = d1;
        req   = r;
        wait_ack();
        req[w] = 1'b0;
    endtask

    initial begin
        logic w;
        logic [15:0] rd0, rd1;
        int pick;

        repeat (3) tick();
        reset = 1'b1;
        req   = 2'b00;
        tick();

        serve(2'b01, 16'd1234, 16'd0);
        serve(2'b11, 16'd5, 16'd42);
        serve(2'b11, 16'd5, 16'd42);
        serve(2'b11, 16'd5, 16'd42);

        serve(2'b01, 16'd0, 16'd0);
        serve(2'b01, 16'd9999, 16'd0);
        serve(2'b01, 16'd10000, 16'd0);
        serve(2'b01, 16'd65535, 16'd0);

        // Request pulses that must never be granted: one during HOLD, one between edges in IDLE.
        serve(2'b01, 16'd321, 16'd0);
        repeat (18) tick();
        data1 = 16'd999;
        req   = 2'b10;
        tick();
        req   = 2'b00;
        wait_idle();
        data0 = 16'd4321;
        req   = 2'b01;
        #2;
        req   = 2'b00;
        repeat (4) tick();

        // Reset in the middle of a conversion, with requester 1 still holding its request.
        wait_idle();
        expect_grant(2'b10, 16'd0, 16'd77, w);
        data1 = 16'd77;
        req   = 2'b10;
        wait_ack();
        repeat (7) tick();
        reset = 1'b0;
        tick();
        tick();
        exp_last = 1'b1;
        expect_grant(2'b10, 16'd0, 16'd77, w);
        reset = 1'b1;
        wait_ack();
        req[1] = 1'b0;

        serve(2'b11, 16'd8, 16'd9);

        for (int i = 0; i < 25; i++) begin
            pick = $urandom_range(0, 9);
            rd0  = 16'($urandom_range(0, 65535));
            rd1  = 16'($urandom_range(0, 65535));
            if (pick == 0) rd0 = 16'd9999;
            if (pick == 1) rd1 = 16'd10000;
            if (pick == 2) rd0 = 16'd0;
            if (pick == 3) rd1 = 16'($urandom_range(0, 9999));
            serve(2'($urandom_range(1, 3)), rd0, rd1);
        end

        wait_idle();
        req = 2'b00;
        repeat (3) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000, SHALL set the minimum number of clock cycles a converted value stays displayed before the next grant; legal values are 1 or more.
REQ-002 Port: clock, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-003 Port: reset, input, 1: synchronous, active-low reset; 0 sampled at a rising clock edge resets the block.
REQ-004 Port: req, input, 2: per-requester display request; bit i belongs to requester i.
REQ-005 Port: data0, input, 16: unsigned binary value from requester 0.
REQ-006 Port: data1, input, 16: unsigned binary value from requester 1.
REQ-007 Port: ack, output, 2: one-cycle grant/capture pulse per requester.
REQ-008 Port: dig0, dig1, dig2, dig3, outputs, 4 each: BCD digits (dig0 = ones, dig3 = thousands); these drive the seven-segment multiplexer inputs in0..in3.
REQ-009 Port: busy, output, 1: high whenever state is not IDLE.
REQ-010 Port: src, output, 1: index of the requester whose value is currently displayed.

Function
REQ-011 States SHALL be IDLE, CONVERT and HOLD, with a 2-bit state register.
REQ-012 In IDLE, at an edge where any req bit is 1, the block SHALL grant exactly one requester, capture that requester's data, and enter CONVERT.
- Call this edge E0.
REQ-013 Arbitration SHALL be round-robin.
- Single request: that requester wins.
- Both requesting: the requester not granted last wins.
- After reset, the last-granted marker SHALL equal 1, so requester 0 wins the first tie.
REQ-014 ack[i] SHALL be a registered output, high for exactly the one cycle following E0; the other ack bit SHALL stay 0.
REQ-015 Requesters SHALL hold req and data stable until they see ack.
- A req that drops before its grant edge SHALL be ignored; no capture.
- A req asserted while busy SHALL be neither acked nor lost; it is evaluated on return to IDLE.
REQ-016 CONVERT SHALL perform a sequential double-dabble conversion, one bit per cycle, over edges E1..E16.
- Working registers: 16-bit shift value and 20-bit BCD accumulator (5 digits).
- Add-3 applies to each BCD nibble of 5 or more before each shift.
REQ-017 At edge E17 the block SHALL load the outputs and enter HOLD:
- if the ten-thousands BCD digit is 0: dig3..dig0 = the four lower BCD digits, with no leading-zero blanking;
- if the value is 10000 or more: all four digits = 4'hA (dash code);
- src = granted index.
REQ-018 dig0..dig3 and src SHALL change only at E17-type edges or at reset; they SHALL hold their value in all other states.
REQ-019 HOLD SHALL last exactly HOLD_CYCLES cycles, using a down-counter sized from the parameter, then return to IDLE.
- IDLE is re-entered at edge E17+HOLD_CYCLES.
- The earliest next grant is edge E18+HOLD_CYCLES.
REQ-020 busy SHALL be 1 from the cycle after E0 through the cycle IDLE is re-entered (exclusive).

Reset
REQ-021 With reset = 0 at a rising edge, the block SHALL set:
- state = IDLE
- ack = 2'b00
- busy = 0
- src = 0
- dig0..dig3 = 4'hA
- last-granted marker = 1
- conversion registers and HOLD counter cleared
REQ-022 Reset mid-CONVERT or mid-HOLD SHALL abandon the operation without updating digits from the partial result. A requester still holding req after reset release SHALL be granted afresh.

Verification
REQ-023 Reset: hold reset = 0 for 3 edges with req = 2'b11 -> ack = 0, busy = 0, all digits 4'hA, src = 0.
REQ-024 Single request: req = 2'b01, data0 = 1234 -> ack[0] high for one cycle after E0; at E17, dig3..dig0 = 1,2,3,4, src = 0, busy = 1; busy falls HOLD_CYCLES cycles later (bench uses HOLD_CYCLES = 4).
REQ-025 Tie and round-robin: req = 2'b11 held, data0 = 5, data1 = 42 -> requester 0 served first (0,0,0,5); then requester 1 (0,0,4,2, src = 1); then requester 0 again.
REQ-026 Boundaries:
- data0 = 0 -> 0,0,0,0
- data0 = 9999 -> 9,9,9,9
- data0 = 10000 -> all 4'hA
- data0 = 65535 -> all 4'hA
REQ-027 Reset mid-CONVERT (at E8) with req[1] held, data1 = 77 -> digits remain 4'hA; after release, ack[1] pulses and digits become 0,0,7,7 at 17 edges after the new grant.
REQ-028 Busy gating: pulse req[1] for one cycle during HOLD -> no ack; a req[0] pulse dropped before its grant edge in IDLE -> no ack, no capture, digits unchanged.
